// File: rtl/flash_pkg.sv
// Shared constants and types for the flash sample reader.
// Word-address/data widths, FSM state encoding and flash read latency.
package flash_pkg;

    localparam int ADDR_W       = 21;
    localparam int DATA_W       = 32;
    localparam int FLASH_RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous prefetch FIFO with occupancy count and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 4,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW     = AW + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CW-1:0]     count_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [CW-1:0]     cnt_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/flash_sample_reader.sv
// Streams a block of flash words into a prefetch FIFO for the audio path.
// Optional SAMPLE_LOOP_EN adds loop_enable for continuous looped playback.
module flash_sample_reader #(
    parameter int ADDR_W     = flash_pkg::ADDR_W,
    parameter int DATA_W     = flash_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              resetN,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
`ifdef SAMPLE_LOOP_EN
    input  logic              loop_enable,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] flash_address,
    output logic [DATA_W-1:0] flash_dataIn,
    output logic              flash_writeEnable,
    output logic              flash_requestCE,
    input  logic [DATA_W-1:0] flash_dataOut,
    input  logic              flash_CE,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready
);

    import flash_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q;
    logic              req_q;
    logic              done_q;
    logic              discard_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] rem_q;
    logic [ADDR_W-1:0] rem_d;
    logic [CW-1:0]     fifo_cnt;
    logic [CW-1:0]     cnt_d;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              credit;
    logic              loop_now;

`ifdef SAMPLE_LOOP_EN
    assign loop_now = loop_enable;
`else
    assign loop_now = 1'b0;
`endif

    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign flash_address     = addr_q;
    assign flash_requestCE   = req_q;
    assign flash_dataIn      = '0;
    assign flash_writeEnable = 1'b0;
    assign sample_valid      = ~fifo_empty;

    assign pop   = sample_valid & sample_ready;
    assign push  = flash_CE & ~discard_q;
    assign cnt_d = fifo_cnt + CW'(push & ~fifo_full) - CW'(pop);
    assign rem_d = rem_q - ADDR_W'(req_q);

    // A word requested this cycle still lands in the FIFO, so it takes a slot
    assign credit = (cnt_d + CW'(req_q)) < CW'(FIFO_DEPTH);

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (resetN),
        .flush_i (stop),
        .push_i  (push),
        .data_i  (flash_dataOut),
        .pop_i   (pop),
        .data_o  (sample_data),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            discard_q <= 1'b0;
            addr_q    <= '0;
            base_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
        end else begin
            done_q    <= 1'b0;
            discard_q <= 1'b0;
            if (stop) begin
                state_q   <= IDLE;
                req_q     <= 1'b0;
                discard_q <= req_q;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            base_q <= base_addr;
                            len_q  <= length;
                            if (length == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= FETCH;
                                req_q   <= 1'b1;
                                addr_q  <= base_addr;
                                rem_q   <= length;
                            end
                        end
                    end
                    FETCH: begin
                        if (req_q) begin
                            addr_q <= addr_q + 1'b1;
                        end
                        rem_q <= rem_d;
                        if (rem_d == '0) begin
                            if (loop_now) begin
                                addr_q <= base_q;
                                rem_q  <= len_q;
                                req_q  <= credit;
                            end else begin
                                state_q <= DRAIN;
                                req_q   <= 1'b0;
                            end
                        end else begin
                            req_q <= credit;
                        end
                    end
                    DRAIN: begin
                        if (pop && !push && fifo_cnt == CW'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
